// File: rtl/counter_sequencer_if.sv
// Configuration channel for counter_sequencer: modulus and wrap count under valid/ready.
// Ready is high only while the sequencer idles; offers outside IDLE are not taken.
interface counter_sequencer_if #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 4
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WIDTH-1:0]  cfg_mod;
    logic [WRAP_W-1:0] cfg_wraps;

    modport master (
        output cfg_valid,
        output cfg_mod,
        output cfg_wraps,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_mod,
        input  cfg_wraps,
        output cfg_ready
    );
endinterface

// File: rtl/counter_sequencer.sv
// Modulo-N run controller with pause/abort, terminal-count and one-cycle done pulse.
// Start to first count is one cycle; config is accepted only in IDLE (ready otherwise low).
module counter_sequencer #(
    parameter int WIDTH       = 3,
    parameter int DEFAULT_MOD = 8,
    parameter int WRAP_W      = 4
) (
    input  logic                input_clock1_1,
    input  logic                input_reset1_2,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    counter_sequencer_if.slave  cfg,
    output logic [WIDTH-1:0]    count,
    output logic                tc,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Modulus needs one extra bit so that 2^WIDTH is representable.
    localparam logic [WIDTH:0] MOD_FULL = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] MOD_DEF  = (WIDTH+1)'(DEFAULT_MOD);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH:0]    mod_reg;
    logic [WRAP_W-1:0] wraps_reg;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              done_q, done_d;

    logic              cfg_fire;
    logic              at_terminal;
    logic              last_wrap;

    assign cfg_fire    = (state_q == S_IDLE) && cfg.cfg_valid;
    assign at_terminal = ({1'b0, count_q} == (mod_reg - 1'b1));
    assign last_wrap   = (wraps_reg != '0) && (wrap_cnt_q == (wraps_reg - 1'b1));

    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            wrap_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wrap_cnt_q <= wrap_cnt_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            mod_reg   <= MOD_DEF;
            wraps_reg <= '0;
        end else if (cfg_fire) begin
            mod_reg   <= (cfg.cfg_mod == '0) ? MOD_FULL : {1'b0, cfg.cfg_mod};
            wraps_reg <= cfg.cfg_wraps;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wrap_cnt_d = wrap_cnt_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (start) begin
                    state_d    = S_RUN;
                    wrap_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (at_terminal) begin
                    // Terminal step wins over pause so a wrap is never stretched.
                    count_d    = '0;
                    wrap_cnt_d = wrap_cnt_q + 1'b1;
                    if (last_wrap) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                count_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign count         = count_q;
    assign tc            = (state_q == S_RUN) && at_terminal;
    assign busy          = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign done          = done_q;
    assign state         = state_q;
    assign cfg.cfg_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;
    localparam int WIDTH  = 3;
    localparam int WRAP_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, stop, pause;
    logic [WIDTH-1:0] count;
    logic tc, busy, done;
    logic [1:0] state;

    counter_sequencer_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) cfg_if ();

    counter_sequencer #(.WIDTH(WIDTH), .DEFAULT_MOD(8), .WRAP_W(WRAP_W)) dut (
        .input_clock1_1 (clk),
        .input_reset1_2 (rst),
        .start          (start),
        .stop           (stop),
        .pause          (pause),
        .cfg            (cfg_if),
        .count          (count),
        .tc             (tc),
        .busy           (busy),
        .done           (done),
        .state          (state)
    );

    int n_chk = 0;
    int n_pass = 0;
    int run_adv, tc_seen, done_seen;

    // Reference model: a run is a position p counting advancing steps; count = p mod M.
    int m_st, m_p, m_mod, m_wraps;

    function automatic int m_count();
        return (m_st == 1 || m_st == 2) ? (m_p % m_mod) : 0;
    endfunction

    function automatic logic [8:0] exp_vec();
        logic [1:0] s;
        logic [2:0] c;
        logic t;
        s = 2'(m_st);
        c = 3'(m_count());
        t = (m_st == 1) && (m_count() == m_mod - 1);
        return {s, c, t, (m_st == 1 || m_st == 2), (m_st == 3), (m_st == 0)};
    endfunction

    function automatic logic [8:0] obs();
        return {state, count, tc, busy, done, cfg_if.cfg_ready};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_st = 0; m_p = 0; m_mod = 8; m_wraps = 0;
        end else begin
            case (m_st)
                0: begin
                    if (cfg_if.cfg_valid) begin
                        m_mod   = (cfg_if.cfg_mod == 0) ? (1 << WIDTH) : int'(cfg_if.cfg_mod);
                        m_wraps = int'(cfg_if.cfg_wraps);
                    end
                    if (start) begin m_st = 1; m_p = 0; end
                end
                1: begin
                    if (stop) m_st = 0;
                    else if (m_p % m_mod == m_mod - 1) begin
                        m_p++;
                        if (m_wraps != 0 && m_p == m_mod * m_wraps) m_st = 3;
                    end else if (pause) m_st = 2;
                    else m_p++;
                end
                2: begin
                    if (stop) m_st = 0;
                    else if (!pause) m_st = 1;
                end
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic step();
        if (state == 2'd1 && !pause && !stop && !rst) run_adv++;
        if (tc) tc_seen++;
        if (done) done_seen++;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_stats();
        run_adv = 0; tc_seen = 0; done_seen = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            step();
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL reset: got %b want %b", obs(), exp_vec());
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        start = 1'b1; step(); start = 1'b0;
        clear_stats();
        repeat (20) begin
            step();
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL free_run: got %b want %b", obs(), exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (tc_seen !== 2 || done_seen !== 0) $display("FAIL free_run_tc: got tc=%0d done=%0d want tc=2 done=0", tc_seen, done_seen);
        else n_pass++;
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic test_wraps();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_mod = 3'd5; cfg_if.cfg_wraps = 4'd2;
        step();
        cfg_if.cfg_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        clear_stats();
        for (int i = 0; i < 40 && state != 2'd3; i++) begin
            step();
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL wraps: got %b want %b", obs(), exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (state !== 2'd3 || done !== 1'b1 || count !== 3'd0)
            $display("FAIL wraps_done: got state=%0d done=%b count=%0d want 3/1/0", state, done, count);
        else n_pass++;
        n_chk++;
        if (run_adv !== 10 || tc_seen !== 2) $display("FAIL wraps_len: got run=%0d tc=%0d want 10/2", run_adv, tc_seen);
        else n_pass++;
        step();
        n_chk++;
        if (state !== 2'd0 || cfg_if.cfg_ready !== 1'b1) $display("FAIL wraps_idle: got state=%0d rdy=%b want 0/1", state, cfg_if.cfg_ready);
        else n_pass++;
    endtask

    task automatic test_pause();
        start = 1'b1; step(); start = 1'b0;
        clear_stats();
        for (int i = 0; i < 10 && count != 3'd3; i++) step();
        pause = 1'b1;
        repeat (4) begin
            step();
            n_chk++;
            if (obs() !== exp_vec() || state !== 2'd2 || count !== 3'd3 || tc !== 1'b0)
                $display("FAIL pause_hold: got %b want %b", obs(), exp_vec());
            else n_pass++;
        end
        pause = 1'b0;
        step();
        n_chk++;
        if (state !== 2'd1 || count !== 3'd3) $display("FAIL pause_resume0: got state=%0d count=%0d want 1/3", state, count);
        else n_pass++;
        step();
        n_chk++;
        if (count !== 3'd4) $display("FAIL pause_resume1: got count=%0d want 4", count);
        else n_pass++;
        for (int i = 0; i < 40 && state != 2'd3; i++) begin
            step();
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL pause_run: got %b want %b", obs(), exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (run_adv !== 10 || state !== 2'd3) $display("FAIL pause_len: got run=%0d state=%0d want 10/3", run_adv, state);
        else n_pass++;
        step();
    endtask

    task automatic test_stop_pause();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10 && count != 3'd2; i++) step();
        stop = 1'b1; pause = 1'b1;
        step();
        stop = 1'b0; pause = 1'b0;
        n_chk++;
        if (obs() !== exp_vec() || state !== 2'd0 || count !== 3'd0 || done !== 1'b0)
            $display("FAIL stop_pause: got %b want %b", obs(), exp_vec());
        else n_pass++;
        step();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_mod = 3'd3; cfg_if.cfg_wraps = 4'd0;
        n_chk++;
        if (cfg_if.cfg_ready !== 1'b1) $display("FAIL stop_cfg_rdy: got %b want 1", cfg_if.cfg_ready);
        else n_pass++;
        step();
        cfg_if.cfg_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        repeat (8) begin
            step();
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL stop_newcfg: got %b want %b", obs(), exp_vec());
            else n_pass++;
        end
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10 && count != 3'd6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_chk++;
        if (obs() !== exp_vec() || state !== 2'd0 || count !== 3'd0)
            $display("FAIL reset_mid: got %b want %b", obs(), exp_vec());
        else n_pass++;
        start = 1'b1; step(); start = 1'b0;
        clear_stats();
        repeat (10) begin
            step();
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL reset_defaults: got %b want %b", obs(), exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (done_seen !== 0 || tc_seen !== 1) $display("FAIL reset_free: got done=%0d tc=%0d want 0/1", done_seen, tc_seen);
        else n_pass++;
    endtask

    task automatic test_cfg_in_run();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_mod = 3'd2; cfg_if.cfg_wraps = 4'd1;
        clear_stats();
        repeat (12) begin
            step();
            n_chk++;
            if (obs() !== exp_vec() || cfg_if.cfg_ready !== 1'b0)
                $display("FAIL cfg_in_run: got %b want %b", obs(), exp_vec());
            else n_pass++;
        end
        cfg_if.cfg_valid = 1'b0;
        n_chk++;
        if (done_seen !== 0) $display("FAIL cfg_ignored: got done=%0d want 0", done_seen);
        else n_pass++;
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic test_cfg_with_start(input logic [2:0] md, input logic [3:0] wr, input int exp_run);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_mod = md; cfg_if.cfg_wraps = wr; start = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0; start = 1'b0;
        clear_stats();
        for (int i = 0; i < 40 && state != 2'd3; i++) begin
            step();
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL cfg_start_m%0d: got %b want %b", md, obs(), exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (run_adv !== exp_run || tc_seen !== int'(wr) || done !== 1'b1)
            $display("FAIL cfg_start_len_m%0d: got run=%0d tc=%0d done=%b want %0d/%0d/1", md, run_adv, tc_seen, done, exp_run, wr);
        else n_pass++;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 9) < 3);
            stop  = ($urandom_range(0, 49) == 0);
            pause = ($urandom_range(0, 4) == 0);
            cfg_if.cfg_valid = ($urandom_range(0, 9) < 3);
            cfg_if.cfg_mod   = 3'($urandom_range(0, 7));
            cfg_if.cfg_wraps = 4'($urandom_range(0, 3));
            step();
            n_chk++;
            if (obs() !== exp_vec()) $display("FAIL random_%0d: got %b want %b", i, obs(), exp_vec());
            else n_pass++;
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_mod = '0; cfg_if.cfg_wraps = '0;
        m_st = 0; m_p = 0; m_mod = 8; m_wraps = 0;
        clear_stats();
        test_reset();
        test_free_run();
        test_wraps();
        test_pause();
        test_stop_pause();
        test_reset_mid_run();
        test_cfg_in_run();
        test_cfg_with_start(3'd4, 4'd1, 4);
        test_cfg_with_start(3'd1, 4'd3, 3);
        test_cfg_with_start(3'd0, 4'd1, 8);
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Synchronous controller that sequences a modulo-N up-counter datapath of the same kind as the team's JK-flip-flop ripple counters, but fully clocked from one clock. It accepts a modulus/wrap-count configuration over a valid/ready handshake, runs the count on start, and supports pause, abort and a terminal-count pulse. It reports completion with a one-cycle done pulse, and sits between the board's push-button inputs and the LED count display.

## Interface
- WIDTH, 3: count width in bits.
- DEFAULT_MOD, 8: modulus loaded at reset; range 1..2^WIDTH.
- WRAP_W, 4: width of the wrap-count configuration.

- input_clock1_1  in  1  single clock; all state changes on its rising edge.
- input_reset1_2  in  1  reset, synchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  abort a run; sampled in RUN and PAUSE.
- pause  in  1  level; holds the count while high in RUN/PAUSE.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration accepted this cycle; equals (state==IDLE).
- cfg_mod  in  WIDTH  new modulus; 0 encodes 2^WIDTH.
- cfg_wraps  in  WRAP_W  wraps per run; 0 = free-running.
- count  out  WIDTH  current count value (registered).
- tc  out  1  terminal count: high when state==RUN and count==mod-1.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  registered one-cycle completion pulse.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- Reset (synchronous, highest priority): state=IDLE, count=0, mod_reg=DEFAULT_MOD, wraps_reg=0, wrap_cnt=0. Outputs tc=0, done=0, busy=0, cfg_ready=1.
- Config: on cfg_valid&&cfg_ready at an edge, load mod_reg and wraps_reg. A mod of 0 is stored as 2^WIDTH. Outside IDLE cfg_ready=0 and cfg_valid is ignored.
- IDLE: count=0. On start: go to RUN with count=0 and wrap_cnt=0. If a config handshake and start occur in the same cycle, the run uses the new config.
- RUN, per edge, priority stop > terminal > pause > increment:
  - stop: go to IDLE, count=0, no done.
  - terminal (count==mod_reg-1): count=0 and wrap_cnt++. If wraps_reg!=0 and wrap_cnt==wraps_reg-1, go to DONE. The terminal step is taken even if pause is high on that cycle.
  - pause: go to PAUSE, count holds.
  - otherwise count++.
- PAUSE: count holds and tc=0. stop goes to IDLE with count=0. pause low returns to RUN; counting resumes on the following edge.
- DONE: done=1 and count=0 for exactly one cycle, then unconditionally IDLE. start is ignored in DONE.
- mod_reg=1: count stays 0 and tc is high every RUN cycle.
- wrap_cnt is WRAP_W bits; in free-running mode it wraps modulo 2^WRAP_W and has no effect.

## Timing
- Start latency: start high at edge k puts RUN with count=0 in cycle k+1; count=1 in cycle k+2.
- A run with modulus M and W wraps (W>0) spends exactly M·W cycles in RUN, excluding paused cycles. done is high in the cycle after the last tc, and IDLE follows one cycle later.
- tc is combinational from registered state and count: no extra latency, glitch-free relative to the clock.
- stop and reset take effect at the next edge; no partial outputs afterwards.
- cfg_ready returns high in the first IDLE cycle after DONE or stop.

## Test plan
- Reset, then start with default config (WIDTH=3) -> count 0,1,…,7,0,1…; tc high exactly when count=7; busy=1; done never asserts.
- Config mod=5, wraps=2, then start -> count 0..4,0..4 (10 RUN cycles), tc high twice; next cycle state=DONE, done=1, count=0; then IDLE with cfg_ready=1.
- mod=5 run, pause high at count=3 for 4 cycles -> count stays 3, state=PAUSE, tc=0; after pause low, count goes 3 then 4 on successive cycles, and total RUN cycles are still 10.
- stop and pause both high at count=2 -> next cycle state=IDLE, count=0, done=0; a cfg_valid with mod=3 one cycle later is accepted.
- Reset asserted mid-run at count=6 -> next cycle IDLE, count=0, mod_reg=8, wraps_reg=0.
- cfg_valid with mod=2 during RUN -> cfg_ready=0, config ignored, count still wraps at 7. Simultaneous cfg (mod=4, wraps=1) and start in IDLE -> count 0..3, then done.
